// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) arithmetic blocks.
//   GF_WIDTH / GF_K : default field degree m and middle-term exponent k of
//                     the trinomial f(x) = x^m + x^k + 1.
//   state_e         : inverter controller states.
//   step_e          : kind of chain step in flight (double or increment).
//   phase_e         : addition-chain phase versus the final squaring.
package gf2m_pkg;

    localparam int GF_WIDTH = 127;
    localparam int GF_K     = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SQR      = 3'd2,
        ST_MUL_REQ  = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    typedef enum logic {
        STEP_DOUBLE = 1'b0,
        STEP_INCR   = 1'b1
    } step_e;

    typedef enum logic {
        PH_CHAIN = 1'b0,
        PH_FINAL = 1'b1
    } phase_e;

endpackage

// File: rtl/gf2m_sqr.sv
// Combinational squarer in GF(2^WIDTH), f(x) = x^WIDTH + x^k + 1.
// Operands use the multiplier bit ordering: bit WIDTH-1 holds the x^0
// coefficient, bit 0 holds x^(WIDTH-1).
//   p : field element to square
//   s : p^2 mod f(x)
module gf2m_sqr
    import gf2m_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH,
    parameter int k     = GF_K
) (
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] s
);

    // Double-length square, indexed by natural exponent.
    logic [2*WIDTH-2:0] wide_s;

    // Spread coefficients to even exponents, then fold every term at or
    // above x^WIDTH back using x^WIDTH = x^k + 1. Folding runs from the top
    // down so a term folded into the upper half is itself folded later.
    always_comb begin
        wide_s = {(2*WIDTH-1){1'b0}};
        s      = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            wide_s[2*i] = p[WIDTH-1-i];
        end
        for (int d = 2*WIDTH-2; d >= WIDTH; d--) begin
            wide_s[d-WIDTH+k] = wide_s[d-WIDTH+k] ^ wide_s[d];
            wide_s[d-WIDTH]   = wide_s[d-WIDTH]   ^ wide_s[d];
            wide_s[d]         = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            s[WIDTH-1-i] = wide_s[i];
        end
    end

endmodule

// File: rtl/gf2m_inv_itoh_tsujii.sv
// Itoh-Tsujii inverter for GF(2^WIDTH), f(x) = x^WIDTH + x^k + 1.
// Squarings are done locally, one per cycle; multiplications are delegated
// to an attached digit-serial multiplier.
//   clk, rst_b          : clock, asynchronous active-low reset
//   start, op_a         : request and operand (sampled only when idle)
//   done, op_c          : completion pulse and a^-1 (held until next result)
//   zero_err            : op_a was zero; reported alongside done
//   mul_start/op_a/op_b : request to the multiplier, operands held until done
//   mul_done, mul_op_c  : multiplier completion and product
// Invariant: beta = a^(2^j - 1) after every completed chain step.
module gf2m_inv_itoh_tsujii
    import gf2m_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH,
    parameter int k     = GF_K,
    parameter int EXP_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    output logic             done,
    output logic [WIDTH-1:0] op_c,
    output logic             zero_err,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_op_a,
    output logic [WIDTH-1:0] mul_op_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_op_c
);

    localparam int               PTR_W     = $clog2(EXP_W);
    // Chain exponent E = WIDTH-1; its MSB is implied by j = 1 at LOAD.
    localparam logic [EXP_W-1:0] E_VAL     = EXP_W'(WIDTH-1);
    localparam logic [EXP_W-1:0] CNT_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_START = PTR_W'(EXP_W-2);
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    state_e             state_r,    state_nxt_s;
    step_e              step_r,     step_nxt_s;
    phase_e             phase_r,    phase_nxt_s;
    logic [WIDTH-1:0]   a_reg_r,    a_reg_nxt_s;
    logic [WIDTH-1:0]   beta_r,     beta_nxt_s;
    logic [WIDTH-1:0]   t_r,        t_nxt_s;
    logic [EXP_W-1:0]   j_r,        j_nxt_s;
    logic [EXP_W-1:0]   sqr_cnt_r,  sqr_cnt_nxt_s;
    logic [PTR_W-1:0]   ptr_r,      ptr_nxt_s;
    logic               done_r,     done_nxt_s;
    logic [WIDTH-1:0]   op_c_r,     op_c_nxt_s;
    logic               zero_err_r, zero_err_nxt_s;
    logic               mul_start_r, mul_start_nxt_s;
    logic [WIDTH-1:0]   mul_op_a_r, mul_op_a_nxt_s;
    logic [WIDTH-1:0]   mul_op_b_r, mul_op_b_nxt_s;

    logic [WIDTH-1:0]   sqr_s;
    logic               cur_bit_s;
    logic [EXP_W-1:0]   j_dbl_s;
    logic [EXP_W-1:0]   j_adv_s;

    gf2m_sqr #(
        .WIDTH (WIDTH),
        .k     (k)
    ) u_sqr (
        .p (beta_r),
        .s (sqr_s)
    );

    assign cur_bit_s = E_VAL[ptr_r];
    assign j_dbl_s   = {j_r[EXP_W-2:0], 1'b0};
    // j after the step that just finished in MUL_WAIT.
    assign j_adv_s   = (step_r == STEP_DOUBLE) ? j_dbl_s : (j_r + CNT_ONE);

    // Next-state and next-output logic for the chain controller.
    always_comb begin
        state_nxt_s     = state_r;
        step_nxt_s      = step_r;
        phase_nxt_s     = phase_r;
        a_reg_nxt_s     = a_reg_r;
        beta_nxt_s      = beta_r;
        t_nxt_s         = t_r;
        j_nxt_s         = j_r;
        sqr_cnt_nxt_s   = sqr_cnt_r;
        ptr_nxt_s       = ptr_r;
        done_nxt_s      = 1'b0;
        op_c_nxt_s      = op_c_r;
        zero_err_nxt_s  = zero_err_r;
        mul_start_nxt_s = 1'b0;
        mul_op_a_nxt_s  = mul_op_a_r;
        mul_op_b_nxt_s  = mul_op_b_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (op_a == ZERO_W) begin
                        state_nxt_s    = ST_DONE;
                        done_nxt_s     = 1'b1;
                        op_c_nxt_s     = ZERO_W;
                        zero_err_nxt_s = 1'b1;
                    end else begin
                        a_reg_nxt_s = op_a;
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                beta_nxt_s    = a_reg_r;
                t_nxt_s       = a_reg_r;
                j_nxt_s       = CNT_ONE;
                ptr_nxt_s     = PTR_START;
                step_nxt_s    = STEP_DOUBLE;
                phase_nxt_s   = PH_CHAIN;
                sqr_cnt_nxt_s = CNT_ONE;
                state_nxt_s   = ST_SQR;
            end
            ST_SQR: begin
                beta_nxt_s    = sqr_s;
                sqr_cnt_nxt_s = sqr_cnt_r - CNT_ONE;
                if (sqr_cnt_r == CNT_ONE) begin
                    if (phase_r == PH_FINAL) begin
                        // Result is registered with done so op_c is valid in the done cycle.
                        state_nxt_s    = ST_DONE;
                        done_nxt_s     = 1'b1;
                        op_c_nxt_s     = sqr_s;
                        zero_err_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = ST_MUL_REQ;
                        mul_start_nxt_s = 1'b1;
                        mul_op_a_nxt_s  = sqr_s;
                        mul_op_b_nxt_s  = (step_r == STEP_DOUBLE) ? t_r : a_reg_r;
                    end
                end else begin
                    state_nxt_s = ST_SQR;
                end
            end
            ST_MUL_REQ: begin
                state_nxt_s = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    beta_nxt_s = mul_op_c;
                    if ((step_r == STEP_DOUBLE) && cur_bit_s) begin
                        j_nxt_s       = j_dbl_s;
                        step_nxt_s    = STEP_INCR;
                        sqr_cnt_nxt_s = CNT_ONE;
                        state_nxt_s   = ST_SQR;
                    end else begin
                        j_nxt_s     = j_adv_s;
                        state_nxt_s = ST_SQR;
                        if (ptr_r != PTR_ZERO) begin
                            ptr_nxt_s     = ptr_r - PTR_ONE;
                            step_nxt_s    = STEP_DOUBLE;
                            sqr_cnt_nxt_s = j_adv_s;
                            t_nxt_s       = mul_op_c;
                        end else begin
                            sqr_cnt_nxt_s = CNT_ONE;
                            phase_nxt_s   = PH_FINAL;
                        end
                    end
                end else begin
                    state_nxt_s = ST_MUL_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                // ST_FINAL is a reserved encoding; recover to idle.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= ST_IDLE;
            step_r      <= STEP_DOUBLE;
            phase_r     <= PH_CHAIN;
            a_reg_r     <= {WIDTH{1'b0}};
            beta_r      <= {WIDTH{1'b0}};
            t_r         <= {WIDTH{1'b0}};
            j_r         <= {EXP_W{1'b0}};
            sqr_cnt_r   <= {EXP_W{1'b0}};
            ptr_r       <= {PTR_W{1'b0}};
            done_r      <= 1'b0;
            op_c_r      <= {WIDTH{1'b0}};
            zero_err_r  <= 1'b0;
            mul_start_r <= 1'b0;
            mul_op_a_r  <= {WIDTH{1'b0}};
            mul_op_b_r  <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            step_r      <= step_nxt_s;
            phase_r     <= phase_nxt_s;
            a_reg_r     <= a_reg_nxt_s;
            beta_r      <= beta_nxt_s;
            t_r         <= t_nxt_s;
            j_r         <= j_nxt_s;
            sqr_cnt_r   <= sqr_cnt_nxt_s;
            ptr_r       <= ptr_nxt_s;
            done_r      <= done_nxt_s;
            op_c_r      <= op_c_nxt_s;
            zero_err_r  <= zero_err_nxt_s;
            mul_start_r <= mul_start_nxt_s;
            mul_op_a_r  <= mul_op_a_nxt_s;
            mul_op_b_r  <= mul_op_b_nxt_s;
        end
    end

    assign done      = done_r;
    assign op_c      = op_c_r;
    assign zero_err  = zero_err_r;
    assign mul_start = mul_start_r;
    assign mul_op_a  = mul_op_a_r;
    assign mul_op_b  = mul_op_b_r;

endmodule
